// File: rtl/mtncl_dr_rx.sv
// MTNCL dual-rail receiver: synchronizes rails, runs a DATA/NULL handshake on ko and queues decoded words.
// Latency rail->push: 3 edges with MTNCL_RX_STABLE_FILTER_EN, else 2; a full FIFO holds ko=1 until a slot frees.
module mtncl_dr_rx #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         dr_t,
  input  logic [WIDTH-1:0]         dr_f,
  output logic                     ko,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     err_illegal,
  output logic                     err_sticky
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {WAIT_DATA = 1'b0, WAIT_NULL = 1'b1} state_t;

  logic [WIDTH-1:0] s1_t_q, s1_f_q, s2_t_q, s2_f_q;
  logic             qual;
`ifdef MTNCL_RX_STABLE_FILTER_EN
  logic [WIDTH-1:0] s3_t_q, s3_f_q;
  assign qual = (s2_t_q == s3_t_q) && (s2_f_q == s3_f_q);
`else
  assign qual = 1'b1;
`endif

  // Rails are asynchronous; s2 is the first sample safe to decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_t_q <= '0;
      s1_f_q <= '0;
      s2_t_q <= '0;
      s2_f_q <= '0;
`ifdef MTNCL_RX_STABLE_FILTER_EN
      s3_t_q <= '0;
      s3_f_q <= '0;
`endif
    end else begin
      s1_t_q <= dr_t;
      s1_f_q <= dr_f;
      s2_t_q <= s1_t_q;
      s2_f_q <= s1_f_q;
`ifdef MTNCL_RX_STABLE_FILTER_EN
      s3_t_q <= s2_t_q;
      s3_f_q <= s2_f_q;
`endif
    end
  end

  logic w_complete, w_null, w_illegal;
  assign w_complete = &(s2_t_q ^ s2_f_q);
  assign w_null     = ~|(s2_t_q | s2_f_q);
  assign w_illegal  = |(s2_t_q & s2_f_q);

  state_t         state_q;
  logic           ko_q, ill_prev_q, err_illegal_q, err_sticky_q;
  logic [CW-1:0]  count_q, count_d;
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic           valid_q, valid_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic           full, push, pop, ill_now;

  assign full    = (count_q == CW'(DEPTH));
  assign push    = qual && w_complete && (state_q == WAIT_DATA) && !full;
  assign pop     = valid_q && out_ready;
  assign ill_now = qual && w_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WAIT_DATA;
      ko_q          <= 1'b1;
      ill_prev_q    <= 1'b0;
      err_illegal_q <= 1'b0;
      err_sticky_q  <= 1'b0;
    end else begin
      // One pulse per contiguous run of qualified illegal samples.
      ill_prev_q    <= ill_now;
      err_illegal_q <= ill_now && !ill_prev_q;
      if (ill_now) err_sticky_q <= 1'b1;
      case (state_q)
        WAIT_DATA: if (push) begin
          state_q <= WAIT_NULL;
          ko_q    <= 1'b0;
        end
        WAIT_NULL: if (qual && w_null) begin
          state_q <= WAIT_DATA;
          ko_q    <= 1'b1;
        end
        default: begin
          state_q <= WAIT_DATA;
          ko_q    <= 1'b1;
        end
      endcase
    end
  end

  // out_valid only counts entries that existed before this edge, so a new word shows one edge after its push.
  always_comb begin
    count_d = count_q + CW'(push) - CW'(pop);
    valid_d = (count_q - CW'(pop)) != '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= s2_t_q;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign ko          = ko_q;
  assign out_data    = mem_q[rd_ptr_q];
  assign out_valid   = valid_q;
  assign fifo_count  = count_q;
  assign err_illegal = err_illegal_q;
  assign err_sticky  = err_sticky_q;
endmodule

// File: doc/mtncl_dr_rx.md
MTNCL_DR_RX -- requirements
Module: mtncl_dr_rx

Interface
REQ-001 Parameter WIDTH, default 2: number of dual-rail bits per word, legal range 1..16.
REQ-002 Parameter DEPTH, default 4: output FIFO depth in words, power of two, legal range 2..16.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 dr_t  input  WIDTH  true rails, asynchronous to clk.
REQ-006 dr_f  input  WIDTH  false rails, asynchronous to clk.
REQ-007 ko  output  1  acknowledge to the sender: 1 = request-for-data (RFD), 0 = request-for-null (RFN); registered.
REQ-008 out_data  output  WIDTH  decoded binary word at the FIFO head; bit i = dr_t[i] of the accepted word.
REQ-009 out_valid  output  1  FIFO not empty.
REQ-010 out_ready  input  1  consumer pop request; a pop occurs when out_valid and out_ready are both 1.
REQ-011 fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 err_illegal  output  1  single-cycle pulse on an illegal code.
REQ-013 err_sticky  output  1  set by any illegal code; cleared only by reset.

Function
REQ-014 Rail inputs SHALL pass through a 2-flop synchronizer (s1, s2), and s2 SHALL also be registered into s3.
REQ-015 Per bit, rails {t,f}: 00 = NULL; 10 = DATA 1; 01 = DATA 0; 11 = illegal.
REQ-016 Word classification:
  - COMPLETE: every bit is DATA.
  - NULLW: every bit is NULL.
  - ILLEGAL: any bit is 11.
  - Otherwise PARTIAL.
REQ-017 FSM states: WAIT_DATA (ko=1) and WAIT_NULL (ko=0).
REQ-018 Acceptance condition: the word is "qualified" as defined in REQ-031.
REQ-019 In WAIT_DATA, if the qualified word is COMPLETE and fifo_count<DEPTH:
  - push the decoded word;
  - go to WAIT_NULL;
  - ko=0 from the same edge.
REQ-020 In WAIT_DATA, if the qualified word is COMPLETE and the FIFO is full: remain in WAIT_DATA with ko=1, and accept on the first cycle with space.
REQ-021 In WAIT_NULL, if the qualified word is NULLW: go to WAIT_DATA, ko=1 from the same edge; nothing is pushed.
REQ-022 PARTIAL words SHALL cause no state change.
REQ-023 COMPLETE words seen in WAIT_NULL SHALL be ignored, giving exactly one push per DATA wavefront.
REQ-024 An ILLEGAL qualified word in either state SHALL:
  - pulse err_illegal for 1 cycle per ILLEGAL episode (on its first cycle);
  - set err_sticky;
  - not push;
  - not change state.
REQ-025 Fullness SHALL be evaluated from the pre-edge fifo_count.
  - When full with a simultaneous pop, the pop completes and the push waits one cycle.
  - When not full, a simultaneous push and pop both complete and fifo_count is unchanged.
REQ-026 There SHALL be no empty-FIFO bypass: out_valid rises on the edge after the push edge.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH.
  - A pop on empty is ignored.
  - out_data is undefined while out_valid=0.

Reset
REQ-028 While rst_n=0, the block SHALL hold:
  - ko=1, state WAIT_DATA;
  - s1/s2/s3 = all-zero;
  - fifo_count=0, out_valid=0, out_data=0;
  - err_illegal=0, err_sticky=0.
REQ-029 Reset asserted mid-operation SHALL flush the FIFO and abandon any wavefront in progress.
REQ-030 After deassertion, the first acceptance SHALL require a fresh qualified word.

Configuration
REQ-031 Macro MTNCL_RX_STABLE_FILTER_EN selects the qualification rule.
  - Defined: a word is qualified only when s2==s3, i.e. stable for 2 samples. Latency from a rail change before edge E to the ko toggle/push is edge E+3.
  - Undefined: s2 alone is qualified, and s3 is removed. Latency is edge E+2.

Verification (WIDTH=2, DEPTH=4, filter enabled)
REQ-032 Reset: drive rst_n=0 with random rails -> ko=1, out_valid=0, fifo_count=0, err_sticky=0.
REQ-033 Single word:
  - Stimulus: dr_t=2'b10, dr_f=2'b01 applied before edge E, out_ready=1.
  - Response: ko=0 after E+3; out_valid=1 and out_data=2'b10 after E+4.
  - Then drive rails 0 before edge F -> ko=1 after F+3.
REQ-034 Backpressure:
  - Stimulus: out_ready=0, push 4 words 00,01,10,11, then present a 5th DATA word 2'b01.
  - Response: fifo_count=4 and ko stays 1.
  - Then one pop: head=00, the 5th word is pushed, fifo_count returns to 4.
REQ-035 Illegal code:
  - Stimulus: dr_t=2'b01, dr_f=2'b01 held for 5 cycles in WAIT_DATA.
  - Response: err_illegal high exactly 1 cycle, err_sticky=1, no push, ko=1.
REQ-036 Reset mid-protocol: assert rst_n=0 while in WAIT_NULL with fifo_count=2 -> ko=1, fifo_count=0 immediately (asynchronous).
REQ-037 Filter check: a 1-cycle PARTIAL->COMPLETE->PARTIAL glitch on the rails -> no push with MTNCL_RX_STABLE_FILTER_EN defined.
